sdr_reply_tx: RTL and testbench

SDR_REPLY_TX -- requirements
Module: sdr_reply_tx

---
 rtl/sdr_reply_pkg.sv | 52 +++++
 rtl/sdr_reply_tx_if.sv | 12 +
 rtl/sdr_reply_arb.sv | 43 ++++
 rtl/sdr_reply_tx.sv | 109 ++++++++++
 tb/tb_sdr_reply_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdr_reply_pkg.sv
// Shared constants, state encoding and payload layout for the SDR reply transmitter.
package sdr_reply_pkg;

  localparam logic [7:0] CODE_DISCOVERY  = 8'h02;
  localparam logic [7:0] CODE_ERASE_DONE = 8'h03;
  localparam logic [7:0] CODE_SEND_MORE  = 8'h04;

  localparam int unsigned PAYLOAD_LEN   = 60;
  localparam int unsigned GRANT_TIMEOUT = 4096;
  localparam int unsigned IDX_W         = $clog2(PAYLOAD_LEN + 1);
  localparam int unsigned WAIT_W        = $clog2(GRANT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0]  byte_idx_t;
  typedef logic [WAIT_W-1:0] wait_cnt_t;

  typedef struct packed {
    logic [7:0]  code;
    logic [47:0] mac;
    logic [7:0]  version;
    logic [7:0]  board;
  } reply_hdr_t;

  // Bytes 13..PAYLOAD_LEN-1 are zero padding.
  function automatic logic [7:0] payload_byte(input byte_idx_t idx, input logic [31:0] seq,
                                              input reply_hdr_t hdr);
    logic [7:0] b;
    case (idx)
      byte_idx_t'(0):  b = seq[31:24];
      byte_idx_t'(1):  b = seq[23:16];
      byte_idx_t'(2):  b = seq[15:8];
      byte_idx_t'(3):  b = seq[7:0];
      byte_idx_t'(4):  b = hdr.code;
      byte_idx_t'(5):  b = hdr.mac[47:40];
      byte_idx_t'(6):  b = hdr.mac[39:32];
      byte_idx_t'(7):  b = hdr.mac[31:24];
      byte_idx_t'(8):  b = hdr.mac[23:16];
      byte_idx_t'(9):  b = hdr.mac[15:8];
      byte_idx_t'(10): b = hdr.mac[7:0];
      byte_idx_t'(11): b = hdr.version;
      byte_idx_t'(12): b = hdr.board;
      default:         b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sdr_reply_tx_if.sv
// Handshake and byte stream between the reply transmitter and the UDP/MAC transmitter.
interface sdr_reply_tx_if;
  logic        udp_tx_request;
  logic        udp_tx_enable;
  logic [10:0] udp_tx_length;
  logic [7:0]  udp_tx_data;

  modport master (output udp_tx_request, output udp_tx_length, output udp_tx_data,
                  input  udp_tx_enable);
  modport slave  (input  udp_tx_request, input  udp_tx_length, input  udp_tx_data,
                  output udp_tx_enable);
endinterface

// File: rtl/sdr_reply_arb.sv
// Fixed-priority request selection (erase > send_more > discovery) with one-cycle ACK pulses.
module sdr_reply_arb
  import sdr_reply_pkg::*;
(
  input  logic       tx_clock,
  input  logic       reset_n,
  input  logic       arb_enable,
  input  logic       erase_done,
  input  logic       send_more,
  input  logic       discovery_reply,
  output logic       sel_valid,
  output logic [7:0] sel_code,
  output logic       erase_ACK,
  output logic       send_more_ACK,
  output logic       discovery_ACK
);

  logic pick_erase, pick_more, pick_disc;

  always_comb begin
    pick_erase = arb_enable & erase_done;
    pick_more  = arb_enable & ~erase_done & send_more;
    pick_disc  = arb_enable & ~erase_done & ~send_more & discovery_reply;
    sel_valid  = pick_erase | pick_more | pick_disc;
    sel_code   = CODE_DISCOVERY;
    if (pick_erase)     sel_code = CODE_ERASE_DONE;
    else if (pick_more) sel_code = CODE_SEND_MORE;
  end

  // Unselected requests are simply left alone; the requester holds them until acknowledged.
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      erase_ACK     <= 1'b0;
      send_more_ACK <= 1'b0;
      discovery_ACK <= 1'b0;
    end else begin
      erase_ACK     <= pick_erase;
      send_more_ACK <= pick_more;
      discovery_ACK <= pick_disc;
    end
  end

endmodule

// File: rtl/sdr_reply_tx.sv
// Builds and streams 60-byte discovery / EPCS status replies to the UDP transmitter.
module sdr_reply_tx
  import sdr_reply_pkg::*;
#(
  parameter logic [31:0] SEQ_INIT = '0  // sequence number value after reset
) (
  input  logic        tx_clock,
  input  logic        reset_n,
  input  logic        discovery_reply,
  input  logic        erase_done,
  input  logic        send_more,
  input  logic [47:0] local_mac,
  input  logic [7:0]  code_version,
  input  logic [7:0]  board_id,
  output logic        discovery_ACK,
  output logic        erase_ACK,
  output logic        send_more_ACK,
  output logic        sending_sync,
  output logic        tx_timeout,
  sdr_reply_tx_if.master udp
);

  state_t     state;
  logic [31:0] seq;
  reply_hdr_t hdr;
  wait_cnt_t  wait_cnt;
  byte_idx_t  byte_idx;
  logic       sel_valid;
  logic [7:0] sel_code;

  assign udp.udp_tx_length = 11'(PAYLOAD_LEN);

  sdr_reply_arb u_arb (
    .tx_clock        (tx_clock),
    .reset_n         (reset_n),
    .arb_enable      (state == ST_IDLE),
    .erase_done      (erase_done),
    .send_more       (send_more),
    .discovery_reply (discovery_reply),
    .sel_valid       (sel_valid),
    .sel_code        (sel_code),
    .erase_ACK       (erase_ACK),
    .send_more_ACK   (send_more_ACK),
    .discovery_ACK   (discovery_ACK)
  );

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      seq                <= SEQ_INIT;
      hdr                <= '0;
      wait_cnt           <= '0;
      byte_idx           <= '0;
      udp.udp_tx_request <= 1'b0;
      udp.udp_tx_data    <= '0;
      sending_sync       <= 1'b0;
      tx_timeout         <= 1'b0;
    end else begin
      tx_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            hdr                <= '{code: sel_code, mac: local_mac,
                                    version: code_version, board: board_id};
            wait_cnt           <= '0;
            udp.udp_tx_request <= 1'b1;
            sending_sync       <= 1'b1;
            state              <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (udp.udp_tx_enable) begin
            udp.udp_tx_request <= 1'b0;
            udp.udp_tx_data    <= payload_byte('0, seq, hdr);
            byte_idx           <= byte_idx_t'(1);
            state              <= ST_SEND;
          end else if (wait_cnt == wait_cnt_t'(GRANT_TIMEOUT - 1)) begin
            tx_timeout         <= 1'b1;
            udp.udp_tx_request <= 1'b0;
            sending_sync       <= 1'b0;
            wait_cnt           <= '0;
            state              <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + wait_cnt_t'(1);
          end
        end
        ST_SEND: begin
          // byte_idx runs one ahead of the byte on the bus; reaching PAYLOAD_LEN closes the packet.
          if (byte_idx == byte_idx_t'(PAYLOAD_LEN)) begin
            udp.udp_tx_data <= '0;
            seq             <= seq + 32'd1;
            byte_idx        <= '0;
            sending_sync    <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            udp.udp_tx_data <= payload_byte(byte_idx, seq, hdr);
            byte_idx        <= byte_idx + byte_idx_t'(1);
          end
        end
        default: begin
          udp.udp_tx_request <= 1'b0;
          sending_sync       <= 1'b0;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_reply_tx.sv
`timescale 1ns/1ps
// Bench for sdr_reply_tx; dut_b shares all stimulus but starts its sequence at 0xFFFFFFFF.
module tb_sdr_reply_tx;

  localparam logic [7:0]  C_DISC      = 8'h02;
  localparam logic [7:0]  C_ERASE     = 8'h03;
  localparam logic [7:0]  C_MORE      = 8'h04;
  localparam int unsigned N_BYTES     = 60;
  localparam int unsigned TIMEOUT_CYC = 4096;

  logic        tx_clock = 1'b0;
  logic        reset_n  = 1'b1;
  logic        discovery_reply, erase_done, send_more;
  logic [47:0] local_mac;
  logic [7:0]  code_version, board_id;
  logic        grant;
  logic        disc_ack_a, erase_ack_a, more_ack_a, sync_a, tmo_a;
  logic        disc_ack_b, erase_ack_b, more_ack_b, sync_b, tmo_b;

  sdr_reply_tx_if udp_a ();
  sdr_reply_tx_if udp_b ();
  assign udp_a.udp_tx_enable = grant;
  assign udp_b.udp_tx_enable = grant;

  always #5 tx_clock = ~tx_clock;

  sdr_reply_tx dut_a (
    .tx_clock(tx_clock), .reset_n(reset_n), .discovery_reply(discovery_reply),
    .erase_done(erase_done), .send_more(send_more), .local_mac(local_mac),
    .code_version(code_version), .board_id(board_id), .discovery_ACK(disc_ack_a),
    .erase_ACK(erase_ack_a), .send_more_ACK(more_ack_a), .sending_sync(sync_a),
    .tx_timeout(tmo_a), .udp(udp_a));

  sdr_reply_tx #(.SEQ_INIT(32'hFFFF_FFFF)) dut_b (
    .tx_clock(tx_clock), .reset_n(reset_n), .discovery_reply(discovery_reply),
    .erase_done(erase_done), .send_more(send_more), .local_mac(local_mac),
    .code_version(code_version), .board_id(board_id), .discovery_ACK(disc_ack_b),
    .erase_ACK(erase_ack_b), .send_more_ACK(more_ack_b), .sending_sync(sync_b),
    .tx_timeout(tmo_b), .udp(udp_b));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned pkt_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge tx_clock);
    #1;
  endtask

  function automatic logic [7:0] expected_code();
    if (erase_done) return C_ERASE;
    if (send_more)  return C_MORE;
    return C_DISC;
  endfunction

  function automatic logic [2:0] ack_for(input logic [7:0] code);
    if (code == C_ERASE) return 3'b100;
    if (code == C_MORE)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [7:0] model_byte(input int k, input logic [31:0] seq,
                                            input logic [7:0] code, input logic [47:0] mac,
                                            input logic [7:0] ver, input logic [7:0] id);
    logic [103:0] hdr;
    hdr = {seq, code, mac, ver, id};
    if (k < 13) return hdr[8*(12-k) +: 8];
    return 8'h00;
  endfunction

  task automatic apply_reset();
    grant   = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_out_a", {disc_ack_a, erase_ack_a, more_ack_a, sync_a, tmo_a,
                        udp_a.udp_tx_request, udp_a.udp_tx_data}, '0);
    check("rst_out_b", {disc_ack_b, erase_ack_b, more_ack_b, sync_b, tmo_b,
                        udp_b.udp_tx_request, udp_b.udp_tx_data}, '0);
    check("rst_len", {udp_a.udp_tx_length, udp_b.udp_tx_length}, {11'd60, 11'd60});
    repeat (3) tick();
    check("rst_hold", {disc_ack_a, erase_ack_a, more_ack_a, udp_a.udp_tx_data,
                       udp_b.udp_tx_data, sync_a}, '0);
    reset_n   = 1'b1;
    pkt_count = 0;
  endtask

  task automatic serve(input int unsigned grant_delay, input logic [2:0] late_req,
                       input int abort_at);
    logic [7:0]  code, ver, id;
    logic [2:0]  exp_ack;
    logic [47:0] mac;
    logic [31:0] seq_a, seq_b;
    int unsigned waited;
    code    = expected_code();
    exp_ack = ack_for(code);
    waited  = 0;
    while (!sync_a && waited < 20) begin
      tick();
      waited++;
    end
    check("start_latency", waited, 1);
    mac = local_mac; ver = code_version; id = board_id;
    check("ack_a", {erase_ack_a, more_ack_a, disc_ack_a}, exp_ack);
    check("ack_b", {erase_ack_b, more_ack_b, disc_ack_b}, exp_ack);
    check("req_rise", {udp_a.udp_tx_request, udp_b.udp_tx_request, sync_b}, 3'b111);
    case (code)
      C_ERASE: erase_done      = 1'b0;
      C_MORE:  send_more       = 1'b0;
      default: discovery_reply = 1'b0;
    endcase
    // Payload fields change after capture; the packet must keep the captured ones.
    local_mac    = {16'($urandom), 32'($urandom)};
    code_version = 8'($urandom);
    board_id     = 8'($urandom);
    for (int unsigned i = 0; i < grant_delay; i++) begin
      tick();
      if (i == 0) check("ack_single", {erase_ack_a, more_ack_a, disc_ack_a}, 3'b000);
    end
    check("req_held", {udp_a.udp_tx_request, sync_a}, 2'b11);
    grant = 1'b1;
    tick();
    grant = 1'($urandom);
    check("req_drop", {udp_a.udp_tx_request, udp_b.udp_tx_request, sync_a}, 3'b001);
    seq_a = 32'(pkt_count);
    seq_b = 32'hFFFF_FFFF + 32'(pkt_count);
    for (int k = 0; k < int'(N_BYTES); k++) begin
      if (k > 0) tick();
      check($sformatf("byte%0d_a", k), udp_a.udp_tx_data, model_byte(k, seq_a, code, mac, ver, id));
      check($sformatf("byte%0d_b", k), udp_b.udp_tx_data, model_byte(k, seq_b, code, mac, ver, id));
      if (k == abort_at) begin
        apply_reset();
        return;
      end
      if (k == int'(N_BYTES) - 1) begin
        grant           = 1'b0;
        erase_done      = erase_done | late_req[2];
        send_more       = send_more | late_req[1];
        discovery_reply = discovery_reply | late_req[0];
      end else begin
        grant = 1'($urandom);
      end
    end
    tick();
    check("end_a", {sync_a, udp_a.udp_tx_data, tmo_a}, '0);
    check("end_b", {sync_b, udp_b.udp_tx_data, tmo_b}, '0);
    pkt_count++;
  endtask

  task automatic timeout_case();
    int unsigned n, drops;
    grant     = 1'b0;
    send_more = 1'b1;
    tick();
    check("tmo_start", {sync_a, more_ack_a, udp_a.udp_tx_request}, 3'b111);
    send_more = 1'b0;
    n = 0;
    drops = 0;
    while (!tmo_a && n < TIMEOUT_CYC + 16) begin
      tick();
      n++;
      if (!tmo_a && !udp_a.udp_tx_request) drops++;
    end
    check("tmo_cycles", n, TIMEOUT_CYC);
    check("tmo_req_held", drops, 0);
    check("tmo_pulse", {tmo_a, tmo_b, udp_a.udp_tx_request, sync_a}, 4'b1100);
    tick();
    check("tmo_single", {tmo_a, tmo_b}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned guard;
    discovery_reply = 1'b0;
    erase_done      = 1'b0;
    send_more       = 1'b0;
    grant           = 1'b0;
    local_mac       = '0;
    code_version    = 8'h11;
    board_id        = 8'h22;
    #2;
    apply_reset();

    local_mac       = 48'h001C_C0A2_13DD;
    code_version    = 8'h35;
    board_id        = 8'h06;
    discovery_reply = 1'b1;
    serve(3, 3'b000, -1);

    apply_reset();
    erase_done      = 1'b1;
    discovery_reply = 1'b1;
    serve($urandom_range(1, 8), 3'b000, -1);
    serve($urandom_range(1, 8), 3'b000, -1);

    timeout_case();
    send_more = 1'b1;
    serve(2, 3'b000, -1);

    for (int it = 0; it < 6; it++) begin
      {erase_done, send_more, discovery_reply} = 3'($urandom_range(1, 7));
      guard = 0;
      while ((erase_done | send_more | discovery_reply) && guard < 12) begin
        serve($urandom_range(1, 12), (guard < 2) ? 3'($urandom) : 3'b000, -1);
        guard++;
      end
    end

    discovery_reply = 1'b1;
    serve(2, 3'b000, 20);
    send_more = 1'b1;
    serve(5, 3'b000, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
